execute_stage: RTL



---
 rtl/execute_stage.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/execute_stage.sv
// rtl/execute_stage.sv - RISC execute stage: single-cycle ALU, iterative multiply, held output
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   operation handshake (in_op, in_dest, src1, src2)
//   out_valid/out_ready result handshake (out_dest, out_result)
//   flags               {N,Z,C,V}, updated on the edge a result or CMP is registered
//   busy                multiply iterating; input is blocked
module execute_stage #(
  parameter int MUL_CYCLES = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  in_op,
  input  logic [3:0]  in_dest,
  input  logic [31:0] src1,
  input  logic [31:0] src2,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [3:0]  out_dest,
  output logic [31:0] out_result,
  output logic [3:0]  flags,
  output logic        busy
);

  typedef enum logic {IDLE, MUL} state_t;

  localparam logic [3:0] OP_ADD = 4'd1;
  localparam logic [3:0] OP_SUB = 4'd2;
  localparam logic [3:0] OP_AND = 4'd3;
  localparam logic [3:0] OP_ORR = 4'd4;
  localparam logic [3:0] OP_EOR = 4'd5;
  localparam logic [3:0] OP_MOV = 4'd6;
  localparam logic [3:0] OP_LSL = 4'd7;
  localparam logic [3:0] OP_LSR = 4'd8;
  localparam logic [3:0] OP_ASR = 4'd9;
  localparam logic [3:0] OP_CMP = 4'd10;
  localparam logic [3:0] OP_MUL = 4'd11;

  state_t      state, state_next;
  logic [31:0] mul_a;
  logic [31:0] mul_b;
  logic [31:0] acc;
  logic [31:0] acc_next;
  logic [5:0]  count;
  logic [3:0]  mul_dest;
  logic        mul_last;
  logic        accept;

  logic [32:0] add_w;
  logic [32:0] sub_w;
  logic [4:0]  sh;
  logic [31:0] alu_res;
  logic        alu_load;
  logic        alu_upd_nz;
  logic        alu_upd_cv;
  logic        alu_c;
  logic        alu_v;

  assign in_ready = (state == IDLE) && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign busy     = (state == MUL);
  assign mul_last = (count == 6'(MUL_CYCLES - 1));

  // mul_a is pre-shifted and mul_b consumed LSB-first, so the current B bit is
  // always mul_b[0] and the matching shifted A is mul_a.
  assign acc_next = acc + (mul_b[0] ? mul_a : 32'd0);

  // Subtract as A + ~B + 1 so bit 32 is the carry, i.e. 1 means no borrow.
  assign add_w = {1'b0, src1} + {1'b0, src2};
  assign sub_w = {1'b0, src1} + {1'b0, ~src2} + 33'd1;
  assign sh    = src2[4:0];

  always_comb begin
    alu_res    = '0;
    alu_load   = 1'b0;
    alu_upd_nz = 1'b0;
    alu_upd_cv = 1'b0;
    alu_c      = 1'b0;
    alu_v      = 1'b0;
    case (in_op)
      OP_ADD: begin
        alu_res    = add_w[31:0];
        alu_load   = 1'b1;
        alu_upd_nz = 1'b1;
        alu_upd_cv = 1'b1;
        alu_c      = add_w[32];
        alu_v      = (src1[31] == src2[31]) && (add_w[31] != src1[31]);
      end
      OP_SUB, OP_CMP: begin
        alu_res    = sub_w[31:0];
        alu_load   = (in_op == OP_SUB);
        alu_upd_nz = 1'b1;
        alu_upd_cv = 1'b1;
        alu_c      = sub_w[32];
        alu_v      = (src1[31] != src2[31]) && (sub_w[31] != src1[31]);
      end
      OP_AND: begin alu_res = src1 & src2; alu_load = 1'b1; alu_upd_nz = 1'b1; end
      OP_ORR: begin alu_res = src1 | src2; alu_load = 1'b1; alu_upd_nz = 1'b1; end
      OP_EOR: begin alu_res = src1 ^ src2; alu_load = 1'b1; alu_upd_nz = 1'b1; end
      OP_MOV: begin alu_res = src2;        alu_load = 1'b1; alu_upd_nz = 1'b1; end
      OP_LSL: begin alu_res = src1 << sh;  alu_load = 1'b1; alu_upd_nz = 1'b1; end
      OP_LSR: begin alu_res = src1 >> sh;  alu_load = 1'b1; alu_upd_nz = 1'b1; end
      OP_ASR: begin
        alu_res    = 32'($signed(src1) >>> sh);
        alu_load   = 1'b1;
        alu_upd_nz = 1'b1;
      end
      default: begin
        alu_res = '0;
      end
    endcase
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (accept && in_op == OP_MUL) state_next = MUL;
      MUL:  if (mul_last) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_result <= '0;
      out_dest   <= '0;
      flags      <= '0;
      mul_a      <= '0;
      mul_b      <= '0;
      acc        <= '0;
      count      <= '0;
      mul_dest   <= '0;
    end else begin
      // Transfer clears out_valid; a result loading below on this edge wins.
      if (out_valid && out_ready) out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (alu_load) begin
              out_valid  <= 1'b1;
              out_result <= alu_res;
              out_dest   <= in_dest;
            end
            if (alu_upd_nz) flags[3:2] <= {alu_res[31], alu_res == 32'd0};
            if (alu_upd_cv) flags[1:0] <= {alu_c, alu_v};
            if (in_op == OP_MUL) begin
              mul_a    <= src1;
              mul_b    <= src2;
              acc      <= '0;
              count    <= '0;
              mul_dest <= in_dest;
            end
          end
        end
        MUL: begin
          acc   <= acc_next;
          mul_a <= mul_a << 1;
          mul_b <= mul_b >> 1;
          count <= count + 6'd1;
          if (mul_last) begin
            out_valid  <= 1'b1;
            out_result <= acc_next;
            out_dest   <= mul_dest;
            flags[3:2] <= {acc_next[31], acc_next == 32'd0};
          end
        end
        default: begin
          count <= '0;
        end
      endcase
    end
  end

endmodule
